// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the execute-stage HI/LO unit: MDop bit positions of
// the one-hot operation vector coming from the ID decoder, the datapath width
// and the unit's FSM state encoding.
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

  localparam int DATA_W = 32;

  // Bit positions inside the one-hot MDop vector
  localparam int MD_DIV   = 7;
  localparam int MD_DIVU  = 6;
  localparam int MD_MULT  = 5;
  localparam int MD_MULTU = 4;
  localparam int MD_MFHI  = 3;
  localparam int MD_MFLO  = 2;
  localparam int MD_MTHI  = 1;
  localparam int MD_MTLO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Issue/result bundle between the EX stage and the HI/LO unit.
//   md_valid  : instruction in EX is valid this cycle
//   MDop      : one-hot {div,divu,mult,multu,mfhi,mflo,mthi,mtlo}, 0 = no op
//   rs_value  : operand A (dividend / multiplicand / mthi-mtlo source)
//   rt_value  : operand B (divisor / multiplier)
//   md_flush  : cancel any in-flight operation
//   md_busy   : op present but not accepted, EX must stall
//   md_result : HI or LO for mfhi/mflo in the accept cycle, else 0
//   hi_out    : architectural HI
//   lo_out    : architectural LO
// master = pipeline side, slave = the unit.
// ---------------------------------------------------------------------------
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic              md_valid;
  logic [7:0]        MDop;
  logic [DATA_W-1:0] rs_value;
  logic [DATA_W-1:0] rt_value;
  logic              md_flush;
  logic              md_busy;
  logic [DATA_W-1:0] md_result;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output md_valid, MDop, rs_value, rt_value, md_flush,
    input  md_busy, md_result, hi_out, lo_out
  );

  modport slave (
    input  md_valid, MDop, rs_value, rt_value, md_flush,
    output md_busy, md_result, hi_out, lo_out
  );

endinterface

// File: rtl/mul_div_unit_divider.sv
// ---------------------------------------------------------------------------
// md_divider
// Restoring radix-2 divider, one quotient bit per clock, working on operand
// magnitudes with the signs re-applied on the outputs.
//   clk, resetn : clock, synchronous active-low reset (control state only)
//   start       : load operands; the first iteration runs on this edge
//   abort       : drop the operation in flight
//   is_signed   : div (1) versus divu (0)
//   a, b        : dividend, divisor
//   done        : the final iteration happens on the coming edge; quotient
//                 and remainder are valid from the following cycle on
//   quotient    : signed-corrected quotient, all ones on divide-by-zero
//   remainder   : signed-corrected remainder (takes the dividend's sign)
// ---------------------------------------------------------------------------
module md_divider
  import mul_div_unit_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;   // dividend bits shift out the top, quotient bits in the bottom
  } div_st_t;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic sgn);
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude
    return (sgn && v[DATA_W-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic div_st_t div_step(input div_st_t s, input logic [DATA_W-1:0] d);
    logic [DATA_W:0] shifted;
    div_st_t         n;
    shifted = {s.rem, s.quo[DATA_W-1]};
    // The partial remainder stays below d, so both outcomes fit in DATA_W bits
    if (shifted >= {1'b0, d}) begin
      n.rem = shifted[DATA_W-1:0] - d;
      n.quo = {s.quo[DATA_W-2:0], 1'b1};
    end else begin
      n.rem = shifted[DATA_W-1:0];
      n.quo = {s.quo[DATA_W-2:0], 1'b0};
    end
    return n;
  endfunction

  logic              running;
  logic [CNT_W-1:0]  cnt;
  div_st_t           st_p0;
  logic [DATA_W-1:0] dvsr_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;
  logic              dz_p0;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  div_st_t           seed;
  div_st_t           init_st;

  always_comb begin
    a_mag    = mag(a, is_signed);
    b_mag    = mag(b, is_signed);
    seed.rem = '0;
    seed.quo = a_mag;
    init_st  = div_step(seed, b_mag);
  end

  // cnt holds the number of iterations already completed
  assign done = running && (cnt == CNT_W'(DIV_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(1);
    end else if (running) begin
      cnt <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

  // ---- iteration register stage ----
  always_ff @(posedge clk) begin
    if (start) begin
      st_p0    <= init_st;
      dvsr_p0  <= b_mag;
      neg_q_p0 <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r_p0 <= is_signed & a[DATA_W-1];
      dz_p0    <= (b == '0);
    end else if (running) begin
      st_p0 <= div_step(st_p0, dvsr_p0);
    end
  end

  // A zero divisor never fails a trial subtraction, so the remainder ends up
  // as |A|; only the quotient needs forcing to all ones.
  always_comb begin
    quotient = neg_q_p0 ? -st_p0.quo : st_p0.quo;
    if (dz_p0) quotient = '1;
    remainder = neg_r_p0 ? -st_p0.rem : st_p0.rem;
  end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Execute-stage HI/LO unit: mult/multu through a MUL_STAGES-deep multiplier
// pipeline, div/divu on an iterative divider, mthi/mtlo/mfhi/mflo in one
// cycle. md_busy holds the issuing instruction until the unit can take it.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   md     : mul_div_unit_if.slave (issue, operands, flush, busy, result, HI/LO)
// Parameters: MUL_STAGES (>=1) multiplier register stages, DIV_STEPS = 32.
// ---------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_STEPS  = 32
) (
  input  logic          clk,
  input  logic          resetn,
  mul_div_unit_if.slave md
);

  md_state_e                state_q;
  logic [DATA_W-1:0]        hi_q;
  logic [DATA_W-1:0]        lo_q;
  logic [MUL_STAGES-1:0]    vld_p;
  logic [2*DATA_W-1:0]      prod_p [MUL_STAGES];

  logic                     op_any;
  logic                     accept;
  logic                     mul_last;
  logic                     acc_mul;
  logic                     acc_div;
  logic                     acc_mthi;
  logic                     acc_mtlo;

  logic signed [DATA_W:0]   mul_a;
  logic signed [DATA_W:0]   mul_b;
  logic signed [2*DATA_W-1:0] mul_prod;

  logic                     div_done;
  logic [DATA_W-1:0]        div_quo;
  logic [DATA_W-1:0]        div_rem;

  assign op_any   = |md.MDop;
  assign accept   = md.md_valid && op_any && (state_q == ST_IDLE) && (vld_p == '0);
  assign mul_last = vld_p[MUL_STAGES-1];

  // A same-cycle flush suppresses every effect of an accept
  assign acc_mul  = accept && !md.md_flush && (md.MDop[MD_MULT] || md.MDop[MD_MULTU]);
  assign acc_div  = accept && !md.md_flush && (md.MDop[MD_DIV]  || md.MDop[MD_DIVU]);
  assign acc_mthi = accept && !md.md_flush && md.MDop[MD_MTHI];
  assign acc_mtlo = accept && !md.md_flush && md.MDop[MD_MTLO];

  assign md.md_busy = resetn && md.md_valid && op_any && !accept;

  always_comb begin
    md.md_result = '0;
    if (resetn && accept) begin
      if (md.MDop[MD_MFHI])      md.md_result = hi_q;
      else if (md.MDop[MD_MFLO]) md.md_result = lo_q;
    end
  end

  assign md.hi_out = hi_q;
  assign md.lo_out = lo_q;

  // 33x33 signed product covers both mult (sign-extended) and multu
  // (zero-extended); only the low 64 bits are architecturally visible.
  assign mul_a    = {md.MDop[MD_MULT] & md.rs_value[DATA_W-1], md.rs_value};
  assign mul_b    = {md.MDop[MD_MULT] & md.rt_value[DATA_W-1], md.rt_value};
  assign mul_prod = (2*DATA_W)'(mul_a * mul_b);

  // ---- multiplier stage p0 .. p(MUL_STAGES-1) ----
  always_ff @(posedge clk) begin
    if (acc_mul) prod_p[0] <= mul_prod;
    for (int i = 1; i < MUL_STAGES; i++) prod_p[i] <= prod_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn || md.md_flush) vld_p <= '0;
    else                        vld_p <= (vld_p << 1) | MUL_STAGES'(acc_mul);
  end

  md_divider #(
    .DIV_STEPS (DIV_STEPS)
  ) u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (acc_div),
    .abort     (md.md_flush),
    .is_signed (md.MDop[MD_DIV]),
    .a         (md.rs_value),
    .b         (md.rt_value),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else if (md.md_flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_mul)      state_q <= ST_MUL;
          else if (acc_div) state_q <= ST_DIV;
        end
        ST_MUL:  if (mul_last) state_q <= ST_IDLE;
        ST_DIV:  if (div_done) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- HI/LO write-back ----
  // Completions and mthi/mtlo never coincide: moves only accept when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!md.md_flush) begin
      if (mul_last) begin
        {hi_q, lo_q} <= prod_p[MUL_STAGES-1];
      end else if (state_q == ST_DONE) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end else begin
        if (acc_mthi) hi_q <= md.rs_value;
        if (acc_mtlo) lo_q <= md.rs_value;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Directed scenarios followed by a random instruction stream, all results
// compared against an arithmetic HI/LO model kept in the bench.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MUL_STAGES = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mul_div_unit_if ifc ();

  mul_div_unit #(
    .MUL_STAGES (MUL_STAGES),
    .DIV_STEPS  (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (ifc.slave)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    ifc.md_valid = 1'b0;
    ifc.MDop     = '0;
    ifc.rs_value = '0;
    ifc.rt_value = '0;
    ifc.md_flush = 1'b0;
  endtask

  // Presents one op and holds it until accepted; returns after the accept edge.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] res);
    bit got_it;
    got_it       = 1'b0;
    stalls       = 0;
    res          = '0;
    ifc.md_valid = 1'b1;
    ifc.MDop     = 8'(1 << op);
    ifc.rs_value = a;
    ifc.rt_value = b;
    while (!got_it) begin
      @(negedge clk);
      if (!ifc.md_busy) begin
        res    = ifc.md_result;
        got_it = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          chk("issue_timeout", 64'(stalls), 64'd0);
          got_it = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  function automatic void div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = 32'(la / lb);
      r  = 32'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic model_op(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    case (op)
      MD_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = 64'(sp); end
      MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = up; end
      MD_DIV:   div_model(1'b1, a, b, lo_m, hi_m);
      MD_DIVU:  div_model(1'b0, a, b, lo_m, hi_m);
      MD_MTHI:  hi_m = a;
      MD_MTLO:  lo_m = a;
      default:  ;
    endcase
  endtask

  task automatic mul_check(input string tag, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int          st;
    logic [31:0] res;
    issue(op, a, b, st, res);
    chk({tag, "_stall"}, 64'(st), 64'd0);
    repeat (MUL_STAGES) @(posedge clk);
    #1;
    model_op(op, a, b);
    chk({tag, "_hi"}, 64'(ifc.hi_out), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(ifc.lo_out), 64'(exp_lo));
  endtask

  task automatic div_check(input string tag, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
    int          st;
    logic [31:0] res;
    issue(op, a, b, st, res);
    model_op(op, a, b);
    issue(MD_MFLO, 32'd0, 32'd0, st, res);
    chk({tag, "_lo"}, 64'(res), 64'(exp_lo));
    issue(MD_MFHI, 32'd0, 32'd0, st, res);
    chk({tag, "_hi"}, 64'(res), 64'(exp_hi));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int          st;
    logic [31:0] res;
    int          op;
    logic [31:0] a, b;
    logic [31:0] hi_save, lo_save;

    // Reset with an mfhi presented: no stall and no result while in reset
    drive_idle();
    resetn       = 1'b0;
    ifc.md_valid = 1'b1;
    ifc.MDop     = 8'(1 << MD_MFHI);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   64'(ifc.md_busy),   64'd0);
    chk("rst_result", 64'(ifc.md_result), 64'd0);
    chk("rst_hi",     64'(ifc.hi_out),    64'd0);
    chk("rst_lo",     64'(ifc.lo_out),    64'd0);
    @(posedge clk);
    #1;
    drive_idle();
    resetn = 1'b1;
    hi_m   = '0;
    lo_m   = '0;

    // mthi / mtlo
    issue(MD_MTHI, 32'h1234, 32'd0, st, res);
    chk("mthi_stall",  64'(st),  64'd0);
    chk("mthi_result", 64'(res), 64'd0);
    issue(MD_MTLO, 32'h5678, 32'd0, st, res);
    chk("mtlo_stall", 64'(st), 64'd0);
    model_op(MD_MTHI, 32'h1234, 32'd0);
    model_op(MD_MTLO, 32'h5678, 32'd0);
    chk("mt_hi", 64'(ifc.hi_out), 64'h1234);
    chk("mt_lo", 64'(ifc.lo_out), 64'h5678);

    // Multiplies
    mul_check("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_check("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // div -7/2 with an mfhi right behind it
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, st, res);
    chk("div_stall", 64'(st), 64'd0);
    model_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(MD_MFHI, 32'd0, 32'd0, st, res);
    chk("div_mfhi_stall",  64'(st),  64'd32);
    chk("div_mfhi_result", 64'(res), 64'hFFFF_FFFF);
    chk("div_lo",          64'(ifc.lo_out), 64'hFFFF_FFFD);

    // Divide by zero and the overflow corner
    div_check("divu_by0", MD_DIVU, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'd100);
    div_check("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // Flush a divide at cycle 10
    hi_save = ifc.hi_out;
    lo_save = ifc.lo_out;
    issue(MD_DIV, 32'd1000, 32'd7, st, res);
    repeat (9) @(posedge clk);
    #1;
    ifc.md_flush = 1'b1;
    @(posedge clk);
    #1;
    ifc.md_flush = 1'b0;
    chk("flush_hi", 64'(ifc.hi_out), 64'(hi_save));
    chk("flush_lo", 64'(ifc.lo_out), 64'(lo_save));
    mul_check("flush_mult", MD_MULT, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_late_hi", 64'(ifc.hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("flush_late_lo", 64'(ifc.lo_out), 64'h0000_0000_FFFF_FFC1);

    // Reset in the middle of a divide
    issue(MD_DIV, 32'd12345, 32'd67, st, res);
    repeat (4) @(posedge clk);
    #1;
    resetn       = 1'b0;
    ifc.md_valid = 1'b1;
    ifc.MDop     = 8'(1 << MD_MFLO);
    @(negedge clk);
    chk("rstmid_busy",   64'(ifc.md_busy),   64'd0);
    chk("rstmid_result", 64'(ifc.md_result), 64'd0);
    @(posedge clk);
    #1;
    drive_idle();
    resetn = 1'b1;
    hi_m   = '0;
    lo_m   = '0;
    chk("rstmid_hi", 64'(ifc.hi_out), 64'd0);
    chk("rstmid_lo", 64'(ifc.lo_out), 64'd0);
    issue(MD_MFHI, 32'd0, 32'd0, st, res);
    chk("rstmid_idle", 64'(st), 64'd0);
    div_check("divu_9_4", MD_DIVU, 32'd9, 32'd4, 32'd2, 32'd1);

    // Random instruction stream
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b, st, res);
      if (op == MD_MFHI) begin
        chk("rnd_mfhi", 64'(res), 64'(hi_m));
        chk("rnd_hi_out", 64'(ifc.hi_out), 64'(hi_m));
      end else if (op == MD_MFLO) begin
        chk("rnd_mflo", 64'(res), 64'(lo_m));
        chk("rnd_lo_out", 64'(ifc.lo_out), 64'(lo_m));
      end else begin
        chk("rnd_res_zero", 64'(res), 64'd0);
        model_op(op, a, b);
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    issue(MD_MFHI, 32'd0, 32'd0, st, res);
    chk("end_mfhi", 64'(res), 64'(hi_m));
    issue(MD_MFLO, 32'd0, 32'd0, st, res);
    chk("end_mflo", 64'(res), 64'(lo_m));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
